if_fetch_unit: RTL and testbench
================================

# if_fetch_unit

Parametrised instruction-fetch stage with a PC generator, a request/grant/response handshake to instruction memory, and a one-entry output register toward decode. It supports branch/jump redirect, decode backpressure and variable-latency memory with one outstanding request. The block sits between the core's control path (redirect source) and the ID stage, and replaces the fixed free-running PC/ROM fetch.

## Interface
- XLEN, 32: PC and redirect width.
- IMEM_AW, 6: instruction-memory word-address width.
- RESET_PC, 32'h0000_0000: PC after reset, word-aligned, truncated to XLEN.

- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  reset, asynchronous, active-high.
- redirect_valid  in  1  load a new PC this cycle.
- redirect_pc  in  XLEN  target PC.
- imem_req  out  1  fetch request.
- imem_addr  out  IMEM_AW  word address, equal to pc[IMEM_AW+1:2].
- imem_gnt  in  1  request accepted this cycle.
- imem_rvalid  in  1  response data valid.
- imem_rdata  in  32  instruction word.
- inst_valid  out  1  output entry valid.
- inst_code  out  32  instruction.
- inst_pc  out  XLEN  PC of inst_code.
- inst_ready  in  1  decode accepts the entry.
- inst_misalign  out  1  entry is a misaligned-target marker (see Configuration).

## Operation
- Registers:
  - pc: next fetch address.
  - pc_if: PC of the in-flight request.
  - Output entry: inst_valid, inst_code, inst_pc, inst_misalign.
  - FSM state.
- FSM states: IDLE, REQ, WAIT, DRAIN, HALT.
- IDLE: imem_req=0. Moves to REQ on the next cycle unconditionally.
- REQ:
  - imem_req = (!inst_valid || inst_ready).
  - On req&&gnt: pc_if<=pc, pc<=pc+4 (modulo 2^XLEN), go to WAIT.
  - imem_addr may change while req is high and gnt is low.
- WAIT: on imem_rvalid, load the output entry {1, rdata, pc_if, 0} and go to REQ.
- Output entry:
  - Cleared when inst_valid&&inst_ready, unless a load happens the same edge.
  - While inst_valid&&!inst_ready, inst_code, inst_pc and inst_misalign are held stable.
- Redirect (highest priority, any state except IDLE):
  - pc<=redirect_pc with bits[1:0] forced to 0, and the output entry is cleared.
  - REQ without gnt: stay in REQ; the new address is presented next cycle.
  - REQ with gnt: the granted request is stale; go to DRAIN.
  - WAIT without rvalid: go to DRAIN.
  - WAIT with rvalid: discard the response; go to REQ.
  - DRAIN: stay in DRAIN.
  - HALT: go to REQ.
- DRAIN: imem_req=0. On rvalid, discard the response and go to REQ.
- imem_rvalid outside WAIT/DRAIN is ignored.
- Only one request is outstanding at a time. A request is issued only when the output entry is free or being consumed, so a response always has room.
- PC bits above IMEM_AW+1 do not reach memory; addresses alias.

## Timing
- Reset values:
  - pc=RESET_PC, pc_if=0, state=IDLE.
  - imem_req=0, imem_addr=RESET_PC[IMEM_AW+1:2].
  - inst_valid=0, inst_code=0, inst_pc=0, inst_misalign=0.
- Reset asserted mid-operation clears everything immediately. A memory response arriving after reset is ignored.
- First imem_req: cycle 1 after rst deassertion.
- Latency: inst_valid rises one edge after imem_rvalid.
- Throughput: with immediate gnt and 1-cycle rvalid, one instruction every 2 cycles.
- Redirect→new imem_addr: 1 cycle, plus any drain time.

## Configuration
- IF_MISALIGN_CHK_EN defined:
  - A redirect with redirect_pc[1:0]!=0 sets an error-pending flag instead of a fetch.
  - Any drain completes normally. Then, rather than issuing a request, the block loads the entry {1, 32'h0, redirect_pc, 1} once the output entry is free, and enters HALT.
  - HALT issues no requests until the next redirect.
- IF_MISALIGN_CHK_EN undefined: low PC bits are silently forced to 0, inst_misalign is tied 0, and HALT is unreachable.

## Structure
- Shared package if_pkg: the FSM state enum and the instruction-width constant.
- One sub-module, if_pc_gen: pc/pc_if registers, increment, and redirect/alignment logic.
- FSM and output entry stay in the top level.

## Test plan
- Reset: hold rst 3 cycles → all outputs at reset values. Release → imem_req=1, imem_addr=0 at cycle 1.
- Sequential fetch: zero-wait memory, rdata=addr+0x100, inst_ready=1 → entries (0x100,0x0), (0x101,0x4), (0x102,0x8), each 2 cycles apart.
- Backpressure: inst_ready=0 for 5 cycles with the entry at pc 0x4 → entry held stable, no imem_req. inst_ready=1 → next request 0x8 issued that cycle.
- Wait states: gnt delayed 3 cycles, rvalid delayed 4 cycles → imem_addr stable until gnt, and the entry carries the correct inst_pc.
- Redirect in WAIT: redirect to 0x40 one cycle before the stale rvalid → stale data never appears, then DRAIN→REQ with imem_addr=0x10. A redirect coinciding with rvalid goes straight to REQ.
- Misalign (macro on): redirect to 0x42 → entry {1, 0, 0x42, 1}, then no requests. Redirect to 0x80 → fetch resumes at 0x80. With the macro off, the same redirect to 0x42 fetches from 0x40.

Source files
------------

// File: rtl/if_pkg.sv
// Shared types for the instruction-fetch stage.
// Holds the fetch FSM state encoding and the instruction width.
package if_pkg;

  localparam int ILEN = 32;

  typedef enum logic [2:0] {
    IDLE,
    REQ,
    WAIT,
    DRAIN,
    HALT
  } if_state_e;

endpackage

// File: rtl/if_pc_gen.sv
// Fetch PC generator: next-fetch pc, in-flight pc_if, increment and redirect.
// Redirect targets are always word-aligned here; misalignment is judged upstream.
module if_pc_gen
  import if_pkg::*;
#(
  parameter int          XLEN     = 32,
  parameter int          IMEM_AW  = 6,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               redirect,
  input  logic [XLEN-1:0]    redirect_pc,
  input  logic               advance,
  output logic [XLEN-1:0]    pc,
  output logic [XLEN-1:0]    pc_if,
  output logic [IMEM_AW-1:0] addr
);

  localparam logic [XLEN-1:0] PC0  = XLEN'(RESET_PC);
  localparam logic [XLEN-1:0] STEP = XLEN'(4);

  logic [1:0] unused_lo;

  assign unused_lo = redirect_pc[1:0];
  assign addr      = pc[IMEM_AW+1:2];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc    <= {PC0[XLEN-1:2], 2'b00};
      pc_if <= '0;
    end else begin
      if (advance) begin
        pc_if <= pc;
      end
      // a redirect overrides the increment of a request granted the same edge
      if (redirect) begin
        pc <= {redirect_pc[XLEN-1:2], 2'b00};
      end else if (advance) begin
        pc <= pc + STEP;
      end
    end
  end

endmodule

// File: rtl/if_fetch_unit.sv
// Fetch stage: FSM, imem handshake and one-entry output register to decode.
// Define IF_MISALIGN_CHK_EN to trap misaligned redirects into a marker + HALT.
module if_fetch_unit
  import if_pkg::*;
#(
  parameter int          XLEN     = 32,
  parameter int          IMEM_AW  = 6,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               redirect_valid,
  input  logic [XLEN-1:0]    redirect_pc,
  output logic               imem_req,
  output logic [IMEM_AW-1:0] imem_addr,
  input  logic               imem_gnt,
  input  logic               imem_rvalid,
  input  logic [ILEN-1:0]    imem_rdata,
  output logic               inst_valid,
  output logic [ILEN-1:0]    inst_code,
  output logic [XLEN-1:0]    inst_pc,
  input  logic               inst_ready,
  output logic               inst_misalign
);

  if_state_e state, state_n;

  logic [XLEN-1:0] pc;
  logic [XLEN-1:0] pc_if;
  logic            redir;
  logic            free;
  logic            adv;
  logic            ld_rsp;
  logic            ld_mark;
  logic            clr;
  logic            err_pend;
  logic [XLEN-1:0] err_pc;

  assign redir   = redirect_valid && (state != IDLE);
  assign free    = !inst_valid || inst_ready;
  assign imem_req = (state == REQ) && !err_pend && free;
  assign adv     = imem_req && imem_gnt;
  assign ld_rsp  = (state == WAIT) && imem_rvalid && !redir;
  assign ld_mark = (state == REQ) && err_pend && free && !redir;
  assign clr     = redir
                || (inst_valid && inst_ready && !ld_rsp && !ld_mark);

  if_pc_gen #(
    .XLEN     (XLEN),
    .IMEM_AW  (IMEM_AW),
    .RESET_PC (RESET_PC)
  ) u_pc_gen (
    .clk         (clk),
    .rst         (rst),
    .redirect    (redir),
    .redirect_pc (redirect_pc),
    .advance     (adv),
    .pc          (pc),
    .pc_if       (pc_if),
    .addr        (imem_addr)
  );

`ifdef IF_MISALIGN_CHK_EN
  logic mis;

  assign mis = |redirect_pc[1:0];

  // the unaligned target is kept verbatim for the marker entry
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_pend <= 1'b0;
      err_pc   <= '0;
    end else if (redir) begin
      err_pend <= mis;
      err_pc   <= redirect_pc;
    end else if (ld_mark) begin
      err_pend <= 1'b0;
    end
  end
`else
  assign err_pend = 1'b0;
  assign err_pc   = '0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_n;
    end
  end

  always_comb begin
    state_n = state;
    unique case (state)
      IDLE: state_n = REQ;
      REQ: begin
        if (redir) begin
          state_n = adv ? DRAIN : REQ;
        end else if (ld_mark) begin
          state_n = HALT;
        end else if (adv) begin
          state_n = WAIT;
        end
      end
      WAIT: begin
        if (imem_rvalid) begin
          state_n = REQ;
        end else if (redir) begin
          state_n = DRAIN;
        end
      end
      DRAIN: begin
        if (imem_rvalid) begin
          state_n = REQ;
        end
      end
      HALT: begin
        if (redir) begin
          state_n = REQ;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      inst_valid    <= 1'b0;
      inst_code     <= '0;
      inst_pc       <= '0;
      inst_misalign <= 1'b0;
    end else begin
      unique case (1'b1)
        ld_rsp: begin
          inst_valid    <= 1'b1;
          inst_code     <= imem_rdata;
          inst_pc       <= pc_if;
          inst_misalign <= 1'b0;
        end
        ld_mark: begin
          inst_valid    <= 1'b1;
          inst_code     <= '0;
          inst_pc       <= err_pc;
          inst_misalign <= 1'b1;
        end
        clr: begin
          inst_valid    <= 1'b0;
          inst_code     <= '0;
          inst_pc       <= '0;
          inst_misalign <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_if_fetch_unit.sv
// Self-checking bench for if_fetch_unit with a reactive imem model.
// Expected entries are queued per scenario and popped on decode handshakes.
module tb_if_fetch_unit;
  import if_pkg::*;

  localparam int XLEN = 32;
  localparam int AW   = 6;

  typedef struct packed {
    logic [31:0] code;
    logic [31:0] pc;
    logic        mis;
  } ent_t;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic            redirect_valid = 1'b0;
  logic [XLEN-1:0] redirect_pc = '0;
  logic            imem_req;
  logic [AW-1:0]   imem_addr;
  logic            imem_gnt = 1'b0;
  logic            imem_rvalid = 1'b0;
  logic [31:0]     imem_rdata = '0;
  logic            inst_valid;
  logic [31:0]     inst_code;
  logic [XLEN-1:0] inst_pc;
  logic            inst_ready = 1'b1;
  logic            inst_misalign;

  int   n_chk = 0;
  int   n_fail = 0;
  ent_t sbq[$];

  int gnt_wait = 0;
  int rsp_wait = 1;
  bit mem_stall = 1'b1;

  always #5 clk = ~clk;

  if_fetch_unit #(
    .XLEN     (XLEN),
    .IMEM_AW  (AW),
    .RESET_PC (32'h0)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .imem_req       (imem_req),
    .imem_addr      (imem_addr),
    .imem_gnt       (imem_gnt),
    .imem_rvalid    (imem_rvalid),
    .imem_rdata     (imem_rdata),
    .inst_valid     (inst_valid),
    .inst_code      (inst_code),
    .inst_pc        (inst_pc),
    .inst_ready     (inst_ready),
    .inst_misalign  (inst_misalign)
  );

  // memory: rdata = word address + 0x100
  initial begin
    bit          outst;
    bit          granted;
    int          rsp_left;
    int          gnt_left;
    logic [AW-1:0] raddr;
    logic [AW-1:0] gaddr;
    outst = 0;
    granted = 0;
    rsp_left = 0;
    gnt_left = 0;
    raddr = '0;
    gaddr = '0;
    forever begin
      @(negedge clk);
      #1;
      if (rst) begin
        outst = 0;
        granted = 0;
        gnt_left = gnt_wait;
        imem_gnt = 0;
        imem_rvalid = 0;
        imem_rdata = '0;
      end else begin
        if (imem_rvalid) outst = 0;
        if (granted) begin
          outst = 1;
          rsp_left = rsp_wait;
          raddr = gaddr;
          gnt_left = gnt_wait;
          granted = 0;
        end
        imem_gnt = 0;
        imem_rvalid = 0;
        imem_rdata = '0;
        if (outst) begin
          if (rsp_left <= 1) begin
            imem_rvalid = 1;
            imem_rdata = 32'h100 + 32'(raddr);
          end else begin
            rsp_left--;
          end
        end else if (imem_req && !mem_stall) begin
          if (gnt_left == 0) begin
            imem_gnt = 1;
            granted = 1;
            gaddr = imem_addr;
          end else begin
            gnt_left--;
          end
        end
      end
    end
  end

  // decode-side monitor
  initial begin
    ent_t e;
    forever begin
      @(negedge clk);
      #2;
      if (!rst && inst_valid && inst_ready) begin
        n_chk++;
        if (sbq.size() == 0) begin
          n_fail++;
          $display("FAIL sb_unexpected: got code=%h pc=%h mis=%b, required no entry",
                   inst_code, inst_pc, inst_misalign);
        end else begin
          e = sbq.pop_front();
          if ({inst_code, inst_pc, inst_misalign} !== {e.code, e.pc, e.mis}) begin
            n_fail++;
            $display("FAIL sb_entry: got code=%h pc=%h mis=%b, required code=%h pc=%h mis=%b",
                     inst_code, inst_pc, inst_misalign, e.code, e.pc, e.mis);
          end
        end
      end
    end
  end

  task automatic do_reset(int n);
    @(negedge clk);
    rst = 1'b1;
    redirect_valid = 1'b0;
    sbq.delete();
    repeat (n) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    mem_stall = 1;
    inst_ready = 1;
    redirect_valid = 0;
    @(negedge clk);
    rst = 1;
    repeat (3) @(negedge clk);
    #2;
    n_chk++;
    if ({imem_req, imem_addr, inst_valid, inst_code, inst_pc, inst_misalign} !== '0) begin
      n_fail++;
      $display("FAIL reset_vals: got req=%b addr=%h v=%b code=%h pc=%h mis=%b, required all 0",
               imem_req, imem_addr, inst_valid, inst_code, inst_pc, inst_misalign);
    end
    @(negedge clk);
    rst = 0;
    #2;
    n_chk++;
    if (imem_req !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_c0_req: got %b, required 0", imem_req);
    end
    @(negedge clk);
    #2;
    n_chk++;
    if (imem_req !== 1'b1 || imem_addr !== 6'h0) begin
      n_fail++;
      $display("FAIL reset_c1_req: got req=%b addr=%h, required req=1 addr=0",
               imem_req, imem_addr);
    end
  endtask

  task automatic test_async_reset();
    gnt_wait = 0;
    rsp_wait = 1;
    mem_stall = 0;
    inst_ready = 0;
    do_reset(2);
    repeat (3) @(negedge clk);
    #2;
    n_chk++;
    if (inst_valid !== 1'b1 || inst_code !== 32'h100) begin
      n_fail++;
      $display("FAIL arst_pre: got v=%b code=%h, required v=1 code=00000100",
               inst_valid, inst_code);
    end
    #1;
    rst = 1;
    #1;
    n_chk++;
    if ({inst_valid, inst_code, inst_pc, imem_req, imem_addr} !== '0) begin
      n_fail++;
      $display("FAIL arst_clear: got v=%b code=%h pc=%h req=%b addr=%h, required all 0",
               inst_valid, inst_code, inst_pc, imem_req, imem_addr);
    end
    inst_ready = 1;
  endtask

  task automatic test_seq();
    logic [AW-1:0] exp_a;
    gnt_wait = 0;
    rsp_wait = 1;
    mem_stall = 0;
    inst_ready = 1;
    do_reset(2);
    sbq.push_back('{32'h100, 32'h0, 1'b0});
    sbq.push_back('{32'h101, 32'h4, 1'b0});
    sbq.push_back('{32'h102, 32'h8, 1'b0});
    for (int c = 1; c <= 8; c++) begin
      @(negedge clk);
      mem_stall = (c >= 7);
      #2;
      n_chk++;
      if (inst_valid !== (c == 3 || c == 5 || c == 7)) begin
        n_fail++;
        $display("FAIL seq_valid c%0d: got %b, required %b",
                 c, inst_valid, (c == 3 || c == 5 || c == 7));
      end
      if (c == 1 || c == 3 || c == 5) begin
        exp_a = AW'((c - 1) / 2);
        n_chk++;
        if (imem_req !== 1'b1 || imem_addr !== exp_a) begin
          n_fail++;
          $display("FAIL seq_req c%0d: got req=%b addr=%h, required req=1 addr=%h",
                   c, imem_req, imem_addr, exp_a);
        end
      end
    end
    @(negedge clk);
    #3;
    n_chk++;
    if (sbq.size() != 0) begin
      n_fail++;
      $display("FAIL seq_drain: got %0d pending, required 0", sbq.size());
    end
  endtask

  task automatic test_backpressure();
    gnt_wait = 0;
    rsp_wait = 1;
    mem_stall = 0;
    inst_ready = 1;
    do_reset(2);
    sbq.push_back('{32'h100, 32'h0, 1'b0});
    sbq.push_back('{32'h101, 32'h4, 1'b0});
    sbq.push_back('{32'h102, 32'h8, 1'b0});
    for (int c = 1; c <= 13; c++) begin
      @(negedge clk);
      if (c == 5) inst_ready = 0;
      if (c == 10) inst_ready = 1;
      mem_stall = (c >= 12);
      #2;
      if (c >= 5 && c <= 9) begin
        n_chk++;
        if ({inst_valid, inst_code, inst_pc, inst_misalign, imem_req}
            !== {1'b1, 32'h101, 32'h4, 1'b0, 1'b0}) begin
          n_fail++;
          $display("FAIL bp_hold c%0d: got v=%b code=%h pc=%h req=%b, required v=1 code=101 pc=4 req=0",
                   c, inst_valid, inst_code, inst_pc, imem_req);
        end
      end
      if (c == 10) begin
        n_chk++;
        if (imem_req !== 1'b1 || imem_addr !== 6'h2) begin
          n_fail++;
          $display("FAIL bp_release: got req=%b addr=%h, required req=1 addr=02",
                   imem_req, imem_addr);
        end
      end
    end
    @(negedge clk);
    #3;
    n_chk++;
    if (sbq.size() != 0) begin
      n_fail++;
      $display("FAIL bp_drain: got %0d pending, required 0", sbq.size());
    end
  endtask

  task automatic test_wait_states();
    gnt_wait = 3;
    rsp_wait = 4;
    mem_stall = 0;
    inst_ready = 1;
    do_reset(2);
    sbq.push_back('{32'h100, 32'h0, 1'b0});
    sbq.push_back('{32'h101, 32'h4, 1'b0});
    for (int c = 1; c <= 17; c++) begin
      @(negedge clk);
      mem_stall = (c >= 16);
      #2;
      if (c <= 4) begin
        n_chk++;
        if (imem_req !== 1'b1 || imem_addr !== 6'h0) begin
          n_fail++;
          $display("FAIL ws_addr0 c%0d: got req=%b addr=%h, required req=1 addr=00",
                   c, imem_req, imem_addr);
        end
      end else if (c <= 8) begin
        n_chk++;
        if (inst_valid !== 1'b0 || imem_req !== 1'b0) begin
          n_fail++;
          $display("FAIL ws_wait c%0d: got v=%b req=%b, required v=0 req=0",
                   c, inst_valid, imem_req);
        end
      end else if (c <= 12) begin
        n_chk++;
        if (imem_req !== 1'b1 || imem_addr !== 6'h1) begin
          n_fail++;
          $display("FAIL ws_addr1 c%0d: got req=%b addr=%h, required req=1 addr=01",
                   c, imem_req, imem_addr);
        end
      end
    end
    @(negedge clk);
    #3;
    n_chk++;
    if (sbq.size() != 0) begin
      n_fail++;
      $display("FAIL ws_drain: got %0d pending, required 0", sbq.size());
    end
  endtask

  task automatic test_redirect();
    gnt_wait = 0;
    rsp_wait = 3;
    mem_stall = 0;
    inst_ready = 1;
    do_reset(2);
    sbq.push_back('{32'h110, 32'h40, 1'b0});
    sbq.push_back('{32'h120, 32'h80, 1'b0});
    for (int c = 1; c <= 18; c++) begin
      @(negedge clk);
      redirect_valid = (c == 3) || (c == 12);
      redirect_pc = (c == 3) ? 32'h40 : 32'h80;
      mem_stall = (c >= 17);
      #2;
      if (c == 4) begin
        n_chk++;
        if (imem_req !== 1'b0 || inst_valid !== 1'b0) begin
          n_fail++;
          $display("FAIL rd_drain: got req=%b v=%b, required req=0 v=0",
                   imem_req, inst_valid);
        end
      end
      if (c == 5) begin
        n_chk++;
        if (imem_req !== 1'b1 || imem_addr !== 6'h10 || inst_valid !== 1'b0) begin
          n_fail++;
          $display("FAIL rd_new_addr: got req=%b addr=%h v=%b, required req=1 addr=10 v=0",
                   imem_req, imem_addr, inst_valid);
        end
      end
      if (c == 13) begin
        n_chk++;
        if (imem_req !== 1'b1 || imem_addr !== 6'h20 || inst_valid !== 1'b0) begin
          n_fail++;
          $display("FAIL rd_rvalid_hit: got req=%b addr=%h v=%b, required req=1 addr=20 v=0",
                   imem_req, imem_addr, inst_valid);
        end
      end
    end
    redirect_valid = 0;
    @(negedge clk);
    #3;
    n_chk++;
    if (sbq.size() != 0) begin
      n_fail++;
      $display("FAIL rd_drain_sb: got %0d pending, required 0", sbq.size());
    end
  endtask

  task automatic test_misalign();
    gnt_wait = 0;
    rsp_wait = 1;
    mem_stall = 0;
    inst_ready = 1;
    do_reset(2);
    sbq.push_back('{32'h100, 32'h0, 1'b0});
`ifdef IF_MISALIGN_CHK_EN
    sbq.push_back('{32'h0, 32'h42, 1'b1});
    sbq.push_back('{32'h120, 32'h80, 1'b0});
    for (int c = 1; c <= 13; c++) begin
      @(negedge clk);
      redirect_valid = (c == 4) || (c == 9);
      redirect_pc = (c == 4) ? 32'h42 : 32'h80;
      mem_stall = (c >= 12);
      #2;
      if (c == 5) begin
        n_chk++;
        if (imem_req !== 1'b0 || inst_valid !== 1'b0) begin
          n_fail++;
          $display("FAIL mis_noreq: got req=%b v=%b, required req=0 v=0",
                   imem_req, inst_valid);
        end
      end
      if (c == 6) begin
        n_chk++;
        if (inst_valid !== 1'b1 || inst_misalign !== 1'b1) begin
          n_fail++;
          $display("FAIL mis_marker: got v=%b mis=%b, required v=1 mis=1",
                   inst_valid, inst_misalign);
        end
      end
      if (c >= 6 && c <= 9) begin
        n_chk++;
        if (imem_req !== 1'b0) begin
          n_fail++;
          $display("FAIL mis_halt c%0d: got req=%b, required 0", c, imem_req);
        end
      end
      if (c == 10) begin
        n_chk++;
        if (imem_req !== 1'b1 || imem_addr !== 6'h20) begin
          n_fail++;
          $display("FAIL mis_resume: got req=%b addr=%h, required req=1 addr=20",
                   imem_req, imem_addr);
        end
      end
    end
`else
    sbq.push_back('{32'h110, 32'h40, 1'b0});
    for (int c = 1; c <= 8; c++) begin
      @(negedge clk);
      redirect_valid = (c == 4);
      redirect_pc = 32'h42;
      mem_stall = (c >= 7);
      #2;
      if (c == 5) begin
        n_chk++;
        if (imem_req !== 1'b1 || imem_addr !== 6'h10) begin
          n_fail++;
          $display("FAIL mis_off_addr: got req=%b addr=%h, required req=1 addr=10",
                   imem_req, imem_addr);
        end
      end
      if (c == 7) begin
        n_chk++;
        if (inst_valid !== 1'b1 || inst_misalign !== 1'b0) begin
          n_fail++;
          $display("FAIL mis_off_flag: got v=%b mis=%b, required v=1 mis=0",
                   inst_valid, inst_misalign);
        end
      end
    end
`endif
    redirect_valid = 0;
    @(negedge clk);
    #3;
    n_chk++;
    if (sbq.size() != 0) begin
      n_fail++;
      $display("FAIL mis_drain: got %0d pending, required 0", sbq.size());
    end
  endtask

  initial begin
    test_reset();
    test_async_reset();
    test_seq();
    test_backpressure();
    test_wait_states();
    test_redirect();
    test_misalign();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
